// File: rtl/aes_pkg.sv
// Shared definitions for the AES core arbiter: core mode encodings and the
// sequencer state type.
package aes_pkg;

    localparam logic [1:0] AES_IDLE = 2'b00;
    localparam logic [1:0] AES_ENC  = 2'b10;
    localparam logic [1:0] AES_DEC  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        WAIT_START,
        WAIT_BUSY,
        DONE,
        ERR
    } arb_state_t;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == AES_ENC) || (mode == AES_DEC);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps to 1 after rollover_val and raises a
// registered flag while the count sits at rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_nxt;
    logic                    flag_nxt;

    always_comb begin
        count_nxt = count_out;
        if (clear)
            count_nxt = '0;
        else if (count_enable)
            count_nxt = (count_out == rollover_val) ? NUM_CNT_BITS'(1)
                                                    : count_out + NUM_CNT_BITS'(1);
        flag_nxt = !clear && (count_nxt == rollover_val);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= count_nxt;
            rollover_flag <= flag_nxt;
        end
    end

endmodule

// File: rtl/aes_arbiter.sv
// Round-robin owner of the shared AES core: grants a requester for a whole
// burst, issues each block, waits out aes_busy and guards it with a watchdog.
module aes_arbiter
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_BITS       = 7
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [1:0]   req_valid,
    input  logic [1:0]   req_last,
    input  logic [1:0]   req_mode0,
    input  logic [1:0]   req_mode1,
    input  logic [127:0] req_data0,
    input  logic [127:0] req_data1,
    output logic [1:0]   grant,
    output logic [1:0]   req_ack,
    output logic [1:0]   req_done,
    output logic [1:0]   aes_mode,
    output logic [127:0] aes_data,
    output logic         data_valid,
    input  logic         aes_busy,
    output logic         error
);

    localparam logic [CNT_BITS-1:0] WD_LIMIT = CNT_BITS'(TIMEOUT_CYCLES);

    arb_state_t          state, state_nxt;
    logic                owner, owner_nxt;
    logic                last_owner, last_r;
    logic [1:0]          mode_r, mode_nxt;
    logic [CNT_BITS-1:0] wd_count;
    logic                wd_flag, wd_expired;
    logic [1:0]          grant_nxt, aes_mode_nxt, ack_nxt, done_nxt;
    logic                dv_nxt;

    flex_counter #(.NUM_CNT_BITS(CNT_BITS)) u_watchdog (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state == WAIT_START),
        .count_enable (state == WAIT_BUSY),
        .rollover_val (WD_LIMIT),
        .count_out    (wd_count),
        .rollover_flag(wd_flag)
    );

    assign wd_expired = wd_flag && (wd_count == WD_LIMIT);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        mode_nxt  = mode_r;
        case (state)
            IDLE: if (|req_valid) begin
                // On a tie the requester that was not served last wins.
                owner_nxt = (req_valid == 2'b11) ? ~last_owner : req_valid[1];
                mode_nxt  = owner_nxt ? req_mode1 : req_mode0;
                state_nxt = GRANT;
            end
            GRANT: begin
                if (!mode_legal(mode_r))
                    state_nxt = ERR;
                else if (req_valid[owner])
                    state_nxt = ISSUE;
            end
            ISSUE:      state_nxt = WAIT_START;
            WAIT_START: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (wd_expired)
                    state_nxt = ERR;
                else if (!aes_busy)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = last_r ? IDLE : GRANT;
            ERR:     if (req_valid == 2'b00) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        grant_nxt    = 2'b00;
        aes_mode_nxt = AES_IDLE;
        if (state_nxt != IDLE && state_nxt != ERR) begin
            grant_nxt    = {owner_nxt, ~owner_nxt};
            aes_mode_nxt = mode_nxt;
        end
    end

    always_comb begin
        dv_nxt   = (state_nxt == ISSUE);
        ack_nxt  = (state_nxt == ISSUE) ? {owner_nxt, ~owner_nxt} : 2'b00;
        done_nxt = (state_nxt == DONE)  ? {owner_nxt, ~owner_nxt} : 2'b00;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            mode_r     <= AES_IDLE;
            last_r     <= 1'b0;
            last_owner <= 1'b1;
            grant      <= 2'b00;
            aes_mode   <= AES_IDLE;
            req_ack    <= 2'b00;
            req_done   <= 2'b00;
            data_valid <= 1'b0;
            aes_data   <= '0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            mode_r     <= mode_nxt;
            grant      <= grant_nxt;
            aes_mode   <= aes_mode_nxt;
            req_ack    <= ack_nxt;
            req_done   <= done_nxt;
            data_valid <= dv_nxt;
            if (state_nxt == ISSUE) begin
                aes_data <= owner_nxt ? req_data1 : req_data0;
                last_r   <= req_last[owner_nxt];
            end
            if (state == DONE && last_r)
                last_owner <= owner;
            if (state_nxt == ERR)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_arbiter.sv
// Randomized bench for aes_arbiter: requester and core models drive the DUT,
// a transaction-level model predicts owner order, data and cycle timing.
module tb_aes_arbiter;
    import aes_pkg::*;

    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [1:0]   req_valid, req_last, req_mode0, req_mode1;
    logic [127:0] req_data0, req_data1;
    logic [1:0]   grant, req_ack, req_done, aes_mode;
    logic [127:0] aes_data;
    logic         data_valid, aes_busy, error;

    always #5 clk = ~clk;

    aes_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_BITS(7)) dut (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_last(req_last),
        .req_mode0(req_mode0), .req_mode1(req_mode1),
        .req_data0(req_data0), .req_data1(req_data1),
        .grant(grant), .req_ack(req_ack), .req_done(req_done),
        .aes_mode(aes_mode), .aes_data(aes_data), .data_valid(data_valid),
        .aes_busy(aes_busy), .error(error)
    );

    typedef struct { logic [127:0] data; logic [1:0] mode; logic last; } blk_t;
    typedef struct { int cyc; logic [1:0] ack; logic [1:0] grant; logic [1:0] mode; logic [127:0] data; } ack_t;
    typedef struct { int cyc; logic [1:0] done; } done_t;
    typedef struct { int owner; logic [127:0] data; logic [1:0] mode; bit first; } exp_t;

    blk_t       q0[$], q1[$];
    int         bq[$];
    ack_t       alog[$];
    done_t      dlog[$];
    logic [1:0] glog[$];
    logic [1:0] hold;
    int         cyc, err_cyc, dv_dup, busy_cnt, b_cur;
    bit         busy_pend, dv_prev;
    int         checks = 0;
    int         failures = 0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_reqs();
        req_valid = {(q1.size() > 0) || hold[1], (q0.size() > 0) || hold[0]};
        if (q0.size() > 0) begin
            req_data0 = q0[0].data; req_mode0 = q0[0].mode; req_last[0] = q0[0].last;
        end else begin
            req_data0 = '0; req_mode0 = AES_IDLE; req_last[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            req_data1 = q1[0].data; req_mode1 = q1[0].mode; req_last[1] = q1[0].last;
        end else begin
            req_data1 = '0; req_mode1 = AES_IDLE; req_last[1] = 1'b0;
        end
    endtask

    // One clock: record DUT events, advance the core and requester models.
    task automatic step();
        ack_t  a;
        done_t d;
        @(negedge clk);
        cyc++;
        glog.push_back(grant);
        if (data_valid) begin
            a.cyc = cyc; a.ack = req_ack; a.grant = grant; a.mode = aes_mode; a.data = aes_data;
            alog.push_back(a);
        end
        if (data_valid && dv_prev) dv_dup++;
        dv_prev = data_valid;
        if (req_done != 2'b00) begin
            d.cyc = cyc; d.done = req_done;
            dlog.push_back(d);
        end
        if (error && err_cyc < 0) err_cyc = cyc;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) aes_busy = 1'b0;
        end
        if (busy_pend) begin
            busy_pend = 1'b0; busy_cnt = b_cur; aes_busy = (b_cur > 0);
        end
        if (data_valid) begin
            busy_pend = 1'b1;
            if (bq.size() > 0) b_cur = bq.pop_front(); else b_cur = 0;
        end
        if (req_ack[0] && q0.size() > 0) void'(q0.pop_front());
        if (req_ack[1] && q1.size() > 0) void'(q1.pop_front());
        drive_reqs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        q0.delete(); q1.delete(); bq.delete(); alog.delete(); dlog.delete(); glog.delete();
        hold = 2'b00; aes_busy = 1'b0; busy_cnt = 0; busy_pend = 1'b0; b_cur = 0;
        drive_reqs();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        cyc = 0; err_cyc = -1; dv_prev = 1'b0; dv_dup = 0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        checks++;
        if ({grant, req_ack, req_done, aes_mode, data_valid, error} !== 10'd0 || aes_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_outputs got grant=%b ack=%b done=%b mode=%b dv=%b err=%b data=%h, need all 0",
                     grant, req_ack, req_done, aes_mode, data_valid, error, aes_data);
        end
        do_reset();
        run(3);
        checks++;
        if (grant !== 2'b00 || data_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL idle_quiet got grant=%b dv=%b err=%b, need 0", grant, data_valid, error);
        end
    endtask

    task automatic test_single();
        blk_t x;
        do_reset();
        x.data = 128'h00112233445566778899AABBCCDDEEFF; x.mode = AES_ENC; x.last = 1'b1;
        q0.push_back(x); bq.push_back(5);
        drive_reqs();
        step();
        checks++;
        if (grant !== 2'b01 || aes_mode !== AES_ENC) begin
            failures++;
            $display("FAIL single_grant got grant=%b mode=%b, need 01/10", grant, aes_mode);
        end
        run(14);
        checks++;
        if (alog.size() !== 1 || dlog.size() !== 1) begin
            failures++;
            $display("FAIL single_count got acks=%0d dones=%0d, need 1/1", alog.size(), dlog.size());
        end else begin
            checks++;
            if (alog[0].cyc !== 2 || alog[0].ack !== 2'b01 || alog[0].data !== x.data) begin
                failures++;
                $display("FAIL single_issue got cyc=%0d ack=%b data=%h, need 2/01/%h",
                         alog[0].cyc, alog[0].ack, alog[0].data, x.data);
            end
            checks++;
            if (dlog[0].cyc !== 9 || dlog[0].done !== 2'b01) begin
                failures++;
                $display("FAIL single_done got cyc=%0d done=%b, need 9/01", dlog[0].cyc, dlog[0].done);
            end
        end
        checks++;
        if (grant !== 2'b00 || dv_dup !== 0 || aes_data !== x.data) begin
            failures++;
            $display("FAIL single_after got grant=%b dv_dup=%0d data=%h, need 00/0/held", grant, dv_dup, aes_data);
        end
    endtask

    task automatic test_tie();
        blk_t x;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            x.data = rnd128(); x.mode = ($urandom_range(0, 1) != 0) ? AES_DEC : AES_ENC; x.last = 1'b1;
            if (i % 2 == 0) q0.push_back(x); else q1.push_back(x);
            bq.push_back($urandom_range(0, 4));
        end
        drive_reqs();
        for (int t = 0; t < 400 && dlog.size() < 4; t++) step();
        checks++;
        if (alog.size() !== 4) begin
            failures++;
            $display("FAIL tie_count got %0d acks, need 4", alog.size());
        end
        for (int k = 0; k < alog.size() && k < 4; k++) begin
            checks++;
            if (alog[k].ack !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL tie_order[%0d] got ack=%b, need %b", k, alog[k].ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
    endtask

    task automatic test_burst();
        blk_t x;
        int   bad;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            x.data = rnd128(); x.mode = (i == 0) ? AES_DEC : AES_ENC; x.last = (i == 2);
            q1.push_back(x); bq.push_back($urandom_range(1, 5));
        end
        drive_reqs();
        step();
        checks++;
        if (grant !== 2'b10 || aes_mode !== AES_DEC) begin
            failures++;
            $display("FAIL burst_grant got grant=%b mode=%b, need 10/11", grant, aes_mode);
        end
        x.data = rnd128(); x.mode = AES_ENC; x.last = 1'b1;
        q0.push_back(x); bq.push_back(2);
        drive_reqs();
        for (int t = 0; t < 400 && !(dlog.size() >= 4 && grant == 2'b00); t++) step();
        checks++;
        if (alog.size() !== 4 || dlog.size() !== 4) begin
            failures++;
            $display("FAIL burst_count got acks=%0d dones=%0d, need 4/4", alog.size(), dlog.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 3; k++)
                if (alog[k].ack !== 2'b10 || alog[k].mode !== AES_DEC || dlog[k].done !== 2'b10) bad++;
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL burst_owner got %0d bad blocks in burst of requester 1, need 0", bad);
            end
            bad = 0;
            for (int i = 0; i < dlog[2].cyc && i < glog.size(); i++)
                if (glog[i] !== 2'b10) bad++;
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL burst_hold got %0d cycles without grant=10 before third done, need 0", bad);
            end
            checks++;
            if (alog[3].ack !== 2'b01 || alog[3].mode !== AES_ENC || alog[3].cyc !== dlog[2].cyc + 3) begin
                failures++;
                $display("FAIL burst_switch got ack=%b mode=%b cyc=%0d, need 01/10/%0d",
                         alog[3].ack, alog[3].mode, alog[3].cyc, dlog[2].cyc + 3);
            end
        end
    endtask

    task automatic test_random();
        blk_t  m0[$], m1[$];
        blk_t  x;
        exp_t  ex[$];
        exp_t  e;
        int    bexp[$];
        int    nb, len, p0, p1, w, n, exp_c;
        bit    lo, a0, a1, fin, first;
        logic [1:0] bmode, oh;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) begin
                    x.data = rnd128(); x.mode = ($urandom_range(0, 1) != 0) ? AES_DEC : AES_ENC;
                    x.last = (k == len - 1);
                    if (r == 0) m0.push_back(x); else m1.push_back(x);
                end
            end
        end
        // Burst-level round robin: whole bursts, alternate on contention.
        p0 = 0; p1 = 0; lo = 1'b1;
        while (p0 < m0.size() || p1 < m1.size()) begin
            a0 = (p0 < m0.size()); a1 = (p1 < m1.size());
            w = (a0 && a1) ? (lo ? 0 : 1) : (a0 ? 0 : 1);
            fin = 1'b0; first = 1'b1;
            while (!fin) begin
                if (w == 0) begin x = m0[p0]; p0++; end else begin x = m1[p1]; p1++; end
                if (first) bmode = x.mode;
                e.owner = w; e.data = x.data; e.mode = bmode; e.first = first;
                ex.push_back(e);
                first = 1'b0; fin = x.last;
            end
            lo = (w == 1);
        end
        n = ex.size();
        for (int k = 0; k < n; k++) bexp.push_back($urandom_range(0, 6));
        q0 = m0; q1 = m1; bq = bexp;
        drive_reqs();
        for (int t = 0; t < 3000 && !(dlog.size() >= n && grant == 2'b00); t++) step();
        checks++;
        if (alog.size() !== n || dlog.size() !== n || dv_dup !== 0) begin
            failures++;
            $display("FAIL rand_count got acks=%0d dones=%0d dv_dup=%0d, need %0d/%0d/0",
                     alog.size(), dlog.size(), dv_dup, n, n);
        end
        for (int k = 0; k < n && k < alog.size() && k < dlog.size(); k++) begin
            oh = (ex[k].owner == 1) ? 2'b10 : 2'b01;
            checks++;
            if (alog[k].ack !== oh || alog[k].grant !== oh || dlog[k].done !== oh) begin
                failures++;
                $display("FAIL rand_owner[%0d] got ack=%b grant=%b done=%b, need %b",
                         k, alog[k].ack, alog[k].grant, dlog[k].done, oh);
            end
            checks++;
            if (alog[k].data !== ex[k].data || alog[k].mode !== ex[k].mode) begin
                failures++;
                $display("FAIL rand_block[%0d] got data=%h mode=%b, need %h/%b",
                         k, alog[k].data, alog[k].mode, ex[k].data, ex[k].mode);
            end
            exp_c = alog[k].cyc + 2 + ((bexp[k] > 1) ? bexp[k] : 1);
            checks++;
            if (dlog[k].cyc !== exp_c) begin
                failures++;
                $display("FAIL rand_done_time[%0d] got %0d, need %0d", k, dlog[k].cyc, exp_c);
            end
            exp_c = (k == 0) ? 2 : dlog[k-1].cyc + (ex[k].first ? 3 : 2);
            checks++;
            if (alog[k].cyc !== exp_c) begin
                failures++;
                $display("FAIL rand_issue_time[%0d] got %0d, need %0d", k, alog[k].cyc, exp_c);
            end
        end
    endtask

    task automatic test_watchdog();
        blk_t x;
        int   bad, st;
        do_reset();
        x.data = rnd128(); x.mode = AES_ENC; x.last = 1'b1;
        q0.push_back(x); bq.push_back(1000);
        hold = 2'b01;
        drive_reqs();
        run(TO + 20);
        checks++;
        if (err_cyc < 2 + TO || err_cyc > 2 + TO + 4 || dlog.size() !== 0) begin
            failures++;
            $display("FAIL wd_trip got err_cyc=%0d dones=%0d, need %0d..%0d/0", err_cyc, dlog.size(), 2 + TO, 2 + TO + 4);
        end
        bad = 0;
        for (int i = (err_cyc > 0 ? err_cyc : glog.size()); i < glog.size(); i++)
            if (glog[i] !== 2'b00) bad++;
        checks++;
        if (bad !== 0 || grant !== 2'b00 || aes_mode !== AES_IDLE || data_valid !== 1'b0 || error !== 1'b1) begin
            failures++;
            $display("FAIL wd_err_state got bad=%0d grant=%b mode=%b dv=%b err=%b, need 0/00/00/0/1",
                     bad, grant, aes_mode, data_valid, error);
        end
        hold = 2'b00; aes_busy = 1'b0; busy_cnt = 0;
        drive_reqs();
        run(2);
        x.data = rnd128(); x.mode = AES_DEC; x.last = 1'b1;
        q1.push_back(x); bq.push_back(2);
        drive_reqs();
        st = cyc;
        run(12);
        checks++;
        if (alog.size() !== 2 || dlog.size() !== 1) begin
            failures++;
            $display("FAIL wd_recover_count got acks=%0d dones=%0d, need 2/1", alog.size(), dlog.size());
        end else begin
            checks++;
            if (alog[1].cyc !== st + 2 || alog[1].ack !== 2'b10 || dlog[0].cyc !== st + 6 || error !== 1'b1) begin
                failures++;
                $display("FAIL wd_recover got ack_cyc=%0d ack=%b done_cyc=%0d err=%b, need %0d/10/%0d/1",
                         alog[1].cyc, alog[1].ack, dlog[0].cyc, error, st + 2, st + 6);
            end
        end
    endtask

    task automatic test_illegal();
        blk_t x;
        do_reset();
        x.data = rnd128(); x.mode = 2'b01; x.last = 1'b1;
        q0.push_back(x);
        drive_reqs();
        run(20);
        checks++;
        if (alog.size() !== 0 || err_cyc < 2 || err_cyc > 3) begin
            failures++;
            $display("FAIL illegal_trip got acks=%0d err_cyc=%0d, need 0/2..3", alog.size(), err_cyc);
        end
        checks++;
        if (error !== 1'b1 || grant !== 2'b00 || aes_mode !== AES_IDLE) begin
            failures++;
            $display("FAIL illegal_state got err=%b grant=%b mode=%b, need 1/00/00", error, grant, aes_mode);
        end
    endtask

    task automatic test_reset_mid();
        blk_t x;
        do_reset();
        x.data = rnd128(); x.mode = AES_ENC; x.last = 1'b1;
        q0.push_back(x); bq.push_back(30);
        drive_reqs();
        run(8);
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({grant, req_ack, req_done, aes_mode, data_valid, error} !== 10'd0 || aes_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_mid got grant=%b ack=%b done=%b mode=%b dv=%b err=%b, need all 0",
                     grant, req_ack, req_done, aes_mode, data_valid, error);
        end
        do_reset();
        x.data = rnd128(); x.mode = AES_DEC; x.last = 1'b1;
        q1.push_back(x); bq.push_back(1);
        drive_reqs();
        run(10);
        checks++;
        if (alog.size() !== 1 || dlog.size() !== 1) begin
            failures++;
            $display("FAIL reset_restart_count got acks=%0d dones=%0d, need 1/1", alog.size(), dlog.size());
        end else begin
            checks++;
            if (alog[0].cyc !== 2 || alog[0].ack !== 2'b10 || alog[0].data !== x.data || dlog[0].cyc !== 5) begin
                failures++;
                $display("FAIL reset_restart got ack_cyc=%0d ack=%b done_cyc=%0d, need 2/10/5",
                         alog[0].cyc, alog[0].ack, dlog[0].cyc);
            end
        end
    endtask

    initial begin
        n_rst = 1'b1; hold = 2'b00; aes_busy = 1'b0;
        busy_cnt = 0; busy_pend = 1'b0; b_cur = 0;
        cyc = 0; err_cyc = -1; dv_prev = 1'b0; dv_dup = 0;
        drive_reqs();
        test_reset();
        test_single();
        test_tie();
        test_burst();
        test_random();
        test_random();
        test_watchdog();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
